// File: rtl/data_memory_2p_if.sv
// Request/response bundle for the two-port data memory.
// The master drives the read and write ports; the slave is the memory.
interface data_memory_2p_if #(
    parameter int unsigned WORD     = 16,
    parameter int unsigned ADDRESSL = 10,
    parameter int unsigned LANE     = 8
);
    logic [ADDRESSL-1:0]  readAddress;
    logic                 memRead;
    logic [WORD-1:0]      readData;
    logic                 readValid;
    logic [ADDRESSL-1:0]  writeAddress;
    logic [WORD-1:0]      writeData;
    logic [WORD/LANE-1:0] writeMask;
    logic                 memWrite;
    logic                 ready;
    logic                 addrError;

    modport master (
        output readAddress, memRead, writeAddress, writeData, writeMask, memWrite,
        input  readData, readValid, ready, addrError
    );

    modport slave (
        input  readAddress, memRead, writeAddress, writeData, writeMask, memWrite,
        output readData, readValid, ready, addrError
    );
endinterface

// File: rtl/data_memory_2p.sv
// Two-port data memory: one registered read port, one lane-masked write port.
// After reset a sequencer sweeps the whole array to zero before accepting requests.
// Same-address read/write collisions are write-first; out-of-range requests are
// dropped (writes) or return zero (reads) and set a sticky error flag.
module data_memory_2p #(
    parameter int unsigned WORD     = 16,
    parameter int unsigned LENGTH   = 1024,
    parameter int unsigned ADDRESSL = 10,
    parameter int unsigned LANE     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    data_memory_2p_if.slave    bus
);

    localparam int unsigned NumLanes = WORD / LANE;
    localparam int unsigned IdxW     = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    // One extra bit so the sweep pointer and the range compare never wrap.
    localparam logic [ADDRESSL:0] LenVal  = (ADDRESSL + 1)'(LENGTH);
    localparam logic [ADDRESSL:0] LastIdx = (ADDRESSL + 1)'(LENGTH - 1);

    typedef enum logic [0:0] {
        StInit,
        StRun
    } state_e;

    state_e              state_q, state_d;
    logic [ADDRESSL:0]   init_ptr_q, init_ptr_d;
    logic                ready_q, ready_d;
    logic                read_valid_q, read_valid_d;
    logic [WORD-1:0]     read_data_q, read_data_d;
    logic                addr_error_q, addr_error_d;

    logic [WORD-1:0]     mem_q [LENGTH];

    logic                rd_in_range;
    logic                wr_in_range;
    logic                collision;
    logic [IdxW-1:0]     rd_idx;
    logic [IdxW-1:0]     wr_idx;
    logic [WORD-1:0]     wr_old;
    logic [WORD-1:0]     wr_merged;

    logic                mem_we;
    logic [IdxW-1:0]     mem_widx;
    logic [WORD-1:0]     mem_wdata;

    assign rd_in_range = {1'b0, bus.readAddress} < LenVal;
    assign wr_in_range = {1'b0, bus.writeAddress} < LenVal;
    assign rd_idx      = bus.readAddress[IdxW-1:0];
    assign wr_idx      = bus.writeAddress[IdxW-1:0];
    assign collision   = bus.memWrite && wr_in_range && rd_in_range &&
                         (bus.readAddress == bus.writeAddress);

    // Merge the masked lanes of the incoming word over the current contents.
    always_comb begin
        wr_old    = '0;
        if (wr_in_range) begin
            wr_old = mem_q[wr_idx];
        end
        wr_merged = wr_old;
        for (int k = 0; k < NumLanes; k++) begin
            if (bus.writeMask[k]) begin
                wr_merged[k*LANE +: LANE] = bus.writeData[k*LANE +: LANE];
            end
        end
    end

    // Select the array write source: zero-fill sweep in INIT, masked write in RUN.
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = '0;
        mem_wdata = '0;
        if (state_q == StInit) begin
            mem_we   = 1'b1;
            mem_widx = init_ptr_q[IdxW-1:0];
        end else if (bus.memWrite && wr_in_range) begin
            mem_we    = 1'b1;
            mem_widx  = wr_idx;
            mem_wdata = wr_merged;
        end
    end

    // Storage array; intentionally not reset, the INIT sweep clears it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

    // Next-state and read-port logic.
    always_comb begin
        state_d      = state_q;
        init_ptr_d   = init_ptr_q;
        ready_d      = ready_q;
        read_valid_d = 1'b0;
        read_data_d  = read_data_q;
        addr_error_d = addr_error_q;
        unique case (state_q)
            StInit: begin
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == LastIdx) begin
                    state_d = StRun;
                    ready_d = 1'b1;
                end
            end
            StRun: begin
                if (bus.memRead) begin
                    read_valid_d = 1'b1;
                    if (!rd_in_range) begin
                        read_data_d  = '0;
                        addr_error_d = 1'b1;
                    end else if (collision) begin
                        read_data_d = wr_merged;
                    end else begin
                        read_data_d = mem_q[rd_idx];
                    end
                end
                if (bus.memWrite && !wr_in_range) begin
                    addr_error_d = 1'b1;
                end
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StInit;
            init_ptr_q   <= '0;
            ready_q      <= 1'b0;
            read_valid_q <= 1'b0;
            read_data_q  <= '0;
            addr_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_ptr_q   <= init_ptr_d;
            ready_q      <= ready_d;
            read_valid_q <= read_valid_d;
            read_data_q  <= read_data_d;
            addr_error_q <= addr_error_d;
        end
    end

    assign bus.ready     = ready_q;
    assign bus.readValid = read_valid_q;
    assign bus.readData  = read_data_q;
    assign bus.addrError = addr_error_q;

endmodule

// File: tb/tb_data_memory_2p.sv
// Bench for data_memory_2p: a full-size instance (LENGTH=1024) and a short one
// (LENGTH=1000) for out-of-range traffic. Expected read data is queued when a
// read is issued and compared when readValid appears.
module tb_data_memory_2p;

    localparam int unsigned Word  = 16;
    localparam int unsigned AddrL = 10;
    localparam int unsigned Lane  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_memory_2p_if #(.WORD(Word), .ADDRESSL(AddrL), .LANE(Lane)) bus_a ();
    data_memory_2p_if #(.WORD(Word), .ADDRESSL(AddrL), .LANE(Lane)) bus_b ();

    data_memory_2p #(.WORD(Word), .LENGTH(1024), .ADDRESSL(AddrL), .LANE(Lane)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    data_memory_2p #(.WORD(Word), .LENGTH(1000), .ADDRESSL(AddrL), .LANE(Lane)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    logic [15:0] model [1024];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                          input logic [1:0] m);
        logic [15:0] r;
        r = old;
        if (m[0]) r[7:0] = d[7:0];
        if (m[1]) r[15:8] = d[15:8];
        return r;
    endfunction

    // Scoreboard: pop an expectation each time a DUT presents read data.
    always @(posedge clk) begin
        #2;
        if (rst_n && bus_a.readValid === 1'b1) begin
            if (q_a.size() == 0) check_val("rv_a_unexpected", bus_a.readValid, 0);
            else check_val("rd_a", bus_a.readData, q_a.pop_front());
        end
        if (rst_n && bus_b.readValid === 1'b1) begin
            if (q_b.size() == 0) check_val("rv_b_unexpected", bus_b.readValid, 0);
            else check_val("rd_b", bus_b.readData, q_b.pop_front());
        end
    end

    task automatic do_a(input bit rd, input logic [9:0] raddr, input bit wr,
                        input logic [9:0] waddr, input logic [15:0] wdata,
                        input logic [1:0] mask, input logic [15:0] exp);
        logic [15:0] held;
        @(negedge clk);
        bus_a.memRead      = rd;
        bus_a.readAddress  = raddr;
        bus_a.memWrite     = wr;
        bus_a.writeAddress = waddr;
        bus_a.writeData    = wdata;
        bus_a.writeMask    = mask;
        if (rd) q_a.push_back(exp);
        if (wr) model[waddr] = merge(model[waddr], wdata, mask);
        @(negedge clk);
        bus_a.memRead  = 1'b0;
        bus_a.memWrite = 1'b0;
        if (rd) begin
            check_val("lat_a", q_a.size(), 0);
            held = bus_a.readData;
            @(posedge clk);
            #3;
            check_val("pulse_a", bus_a.readValid, 0);
            check_val("hold_a", bus_a.readData, held);
        end
    endtask

    task automatic do_b(input bit rd, input logic [9:0] raddr, input bit wr,
                        input logic [9:0] waddr, input logic [15:0] wdata,
                        input logic [1:0] mask, input logic [15:0] exp);
        @(negedge clk);
        bus_b.memRead      = rd;
        bus_b.readAddress  = raddr;
        bus_b.memWrite     = wr;
        bus_b.writeAddress = waddr;
        bus_b.writeData    = wdata;
        bus_b.writeMask    = mask;
        if (rd) q_b.push_back(exp);
        @(negedge clk);
        bus_b.memRead  = 1'b0;
        bus_b.memWrite = 1'b0;
        if (rd) check_val("lat_b", q_b.size(), 0);
    endtask

    // Count edges until instance A is ready (or limit), checking INIT outputs each edge.
    task automatic count_init(input int limit, output int ea, output int eb);
        bit done;
        done = 1'b0;
        ea = 0;
        eb = 0;
        for (int i = 0; i < limit && !done; i++) begin
            @(posedge clk);
            #3;
            ea++;
            if (eb == 0 && bus_b.ready === 1'b1) eb = ea;
            if (bus_a.ready === 1'b1) begin
                done = 1'b1;
            end else begin
                check_val("init_rv_a", bus_a.readValid, 0);
                check_val("init_rd_a", bus_a.readData, 0);
                check_val("init_aerr_a", bus_a.addrError, 0);
            end
        end
    endtask

    initial begin
        int ea;
        int eb;
        bit rd;
        bit wr;
        logic [9:0] ra;
        logic [9:0] wa;
        logic [15:0] wd;
        logic [1:0] m;
        logic [15:0] e;

        bus_a.memRead = 1'b0; bus_a.readAddress = '0; bus_a.memWrite = 1'b0;
        bus_a.writeAddress = '0; bus_a.writeData = '0; bus_a.writeMask = '0;
        bus_b.memRead = 1'b0; bus_b.readAddress = '0; bus_b.memWrite = 1'b0;
        bus_b.writeAddress = '0; bus_b.writeData = '0; bus_b.writeMask = '0;
        for (int i = 0; i < 1024; i++) model[i] = '0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_ready_a", bus_a.ready, 0);
        check_val("rst_rv_a", bus_a.readValid, 0);
        check_val("rst_rd_a", bus_a.readData, 0);
        check_val("rst_aerr_a", bus_a.addrError, 0);
        check_val("rst_ready_b", bus_b.ready, 0);

        // Requests held throughout INIT must be ignored.
        bus_a.memWrite = 1'b1; bus_a.writeAddress = 10'd5; bus_a.writeData = 16'hBEEF;
        bus_a.writeMask = 2'b11; bus_a.memRead = 1'b1; bus_a.readAddress = 10'd5;
        rst_n = 1'b1;
        count_init(2000, ea, eb);
        bus_a.memWrite = 1'b0;
        bus_a.memRead  = 1'b0;
        check_val("init_len_a", ea, 1024);
        check_val("init_len_b", eb, 1000);
        check_val("init_ready_a", bus_a.ready, 1);

        do_a(1, 10'd5, 0, 10'd0, 16'h0, 2'b00, 16'h0000);

        // Masked writes.
        do_a(0, 10'd0, 1, 10'd3, 16'h1234, 2'b11, 16'h0);
        do_a(0, 10'd0, 1, 10'd3, 16'hAB00, 2'b10, 16'h0);
        do_a(1, 10'd3, 0, 10'd0, 16'h0, 2'b00, 16'hAB34);
        do_a(0, 10'd0, 1, 10'd3, 16'hFFCD, 2'b01, 16'h0);
        do_a(1, 10'd3, 0, 10'd0, 16'h0, 2'b00, 16'hABCD);

        // Collision, then an all-zero mask no-op.
        do_a(0, 10'd0, 1, 10'd7, 16'h00FF, 2'b11, 16'h0);
        do_a(1, 10'd7, 1, 10'd7, 16'h5500, 2'b10, 16'h55FF);
        do_a(1, 10'd7, 0, 10'd0, 16'h0, 2'b00, 16'h55FF);
        do_a(0, 10'd0, 1, 10'd7, 16'h1111, 2'b00, 16'h0);
        do_a(1, 10'd7, 0, 10'd0, 16'h0, 2'b00, 16'h55FF);

        // Mixed random traffic on a small address window against the model.
        for (int i = 0; i < 40; i++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            ra = 10'($urandom_range(0, 15));
            wa = 10'($urandom_range(0, 15));
            wd = 16'($urandom);
            m  = 2'($urandom_range(0, 3));
            e  = (wr && wa == ra) ? merge(model[ra], wd, m) : model[ra];
            do_a(rd, ra, wr, wa, wd, m, e);
        end
        check_val("aerr_a_clean", bus_a.addrError, 0);

        // Out-of-range behaviour on the short instance.
        check_val("aerr_b_init", bus_b.addrError, 0);
        do_b(1, 10'd1010, 0, 10'd0, 16'h0, 2'b00, 16'h0000);
        check_val("aerr_b_rd", bus_b.addrError, 1);
        do_b(0, 10'd0, 1, 10'd999, 16'h1111, 2'b11, 16'h0);
        do_b(0, 10'd0, 1, 10'd1020, 16'h2222, 2'b11, 16'h0);
        do_b(1, 10'd999, 0, 10'd0, 16'h0, 2'b00, 16'h1111);
        do_b(1, 10'd1010, 1, 10'd998, 16'h3333, 2'b11, 16'h0000);
        do_b(1, 10'd998, 0, 10'd0, 16'h0, 2'b00, 16'h3333);
        do_b(1, 10'd999, 1, 10'd1020, 16'h4444, 2'b11, 16'h1111);
        do_b(1, 10'd999, 0, 10'd0, 16'h0, 2'b00, 16'h1111);
        check_val("aerr_b_sticky", bus_b.addrError, 1);

        // Reset in RUN: ready drops at once and contents are wiped.
        do_a(0, 10'd0, 1, 10'd9, 16'hCAFE, 2'b11, 16'h0);
        do_a(1, 10'd9, 0, 10'd0, 16'h0, 2'b00, 16'hCAFE);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("async_ready_a", bus_a.ready, 0);
        check_val("async_ready_b", bus_b.ready, 0);
        check_val("async_aerr_b", bus_b.addrError, 0);
        check_val("q_a_empty_rst", q_a.size(), 0);
        check_val("q_b_empty_rst", q_b.size(), 0);
        for (int i = 0; i < 1024; i++) model[i] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset again partway through INIT; the sweep restarts from zero.
        count_init(500, ea, eb);
        check_val("mid_init_edges", ea, 500);
        check_val("mid_init_ready", bus_a.ready, 0);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        count_init(2000, ea, eb);
        check_val("reinit_len_a", ea, 1024);
        check_val("reinit_len_b", eb, 1000);

        do_a(1, 10'd9, 0, 10'd0, 16'h0, 2'b00, 16'h0000);
        do_a(1, 10'd3, 0, 10'd0, 16'h0, 2'b00, 16'h0000);
        do_b(1, 10'd999, 0, 10'd0, 16'h0, 2'b00, 16'h0000);
        check_val("aerr_b_after_rst", bus_b.addrError, 0);

        repeat (2) @(negedge clk);
        check_val("q_a_drained", q_a.size(), 0);
        check_val("q_b_drained", q_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
